// File: rtl/pmod_step_monitor.sv
//==============================================================================
// Module  : pmod_step_monitor
// Brief   : Decodes a full-step coil pattern into steps, direction, position and errors.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pmod_step_monitor #(
   parameter int POS_W         = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 8,
   parameter int IDLE_TIMEOUT  = 1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              signal_in,
   input  logic [1:0]              limit_in,
   input  logic                    clr_err,
   output logic signed [POS_W-1:0] position,
   output logic                    step_pulse,
   output logic                    dir,
   output logic                    moving,
   output logic                    at_home,
   output logic                    at_end,
   output logic                    err_skip,
   output logic                    err_illegal
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]        C_STABLE  = CNT_W'(STABLE_CYCLES);
   localparam logic [IDLE_W-1:0]       C_IDLE    = IDLE_W'(IDLE_TIMEOUT);
   localparam logic signed [POS_W-1:0] C_POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] C_POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_LOST  = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   logic [SYNC_STAGES-1:0][3:0] r_sig_sync;
   logic [SYNC_STAGES-1:0][1:0] r_lim_sync;
   logic [3:0]                  r_cand;
   logic [CNT_W-1:0]            r_cnt;
   logic [3:0]                  r_last;
   logic [IDLE_W-1:0]           r_idle;

   logic [3:0]       w_sample;
   logic             w_match;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_reach;
   logic             w_accept;
   logic             w_onehot;
   logic             w_zero;
   logic [3:0]       w_fwd;
   logic [3:0]       w_rev;
   logic             w_inc;
   logic             w_dec;
   logic             w_set_skip;
   logic             w_set_ill;

   // Index 0 is the newest stage; the oldest stage feeds the decoder.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sig_sync <= '0;
         r_lim_sync <= '0;
      end else begin
         r_sig_sync <= {r_sig_sync[SYNC_STAGES-2:0], signal_in};
         r_lim_sync <= {r_lim_sync[SYNC_STAGES-2:0], limit_in};
      end
   end

   assign w_sample = r_sig_sync[SYNC_STAGES-1];
   assign at_home  = r_lim_sync[SYNC_STAGES-1][0];
   assign at_end   = r_lim_sync[SYNC_STAGES-1][1];

   assign w_match = (w_sample == r_cand);

   always_comb begin
      w_cnt_next = CNT_W'(1);
      if (w_match) begin
         w_cnt_next = (r_cnt == C_STABLE) ? r_cnt : r_cnt + CNT_W'(1);
      end
   end

   // Acceptance happens once, on the edge the counter first reaches the threshold.
   assign w_reach  = (w_cnt_next == C_STABLE) && !(w_match && (r_cnt == C_STABLE));
   assign w_accept = w_reach && (w_sample != r_last);

   assign w_zero   = (w_sample == 4'b0000);
   assign w_onehot = !w_zero && ((w_sample & (w_sample - 4'd1)) == 4'b0000);
   assign w_fwd    = {r_last[0], r_last[3:1]};
   assign w_rev    = {r_last[2:0], r_last[3]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_inc        = 1'b0;
      w_dec        = 1'b0;
      w_set_skip   = 1'b0;
      w_set_ill    = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (w_onehot) begin
                  w_state_next = ST_TRACK;
               end else if (!w_zero) begin
                  w_set_ill    = 1'b1;
                  w_state_next = ST_LOST;
               end
            end
            ST_TRACK: begin
               if (w_zero) begin
                  w_state_next = ST_IDLE;
               end else if (!w_onehot) begin
                  w_set_ill    = 1'b1;
                  w_state_next = ST_LOST;
               end else if (w_sample == w_fwd) begin
                  w_inc = 1'b1;
               end else if (w_sample == w_rev) begin
                  w_dec = 1'b1;
               end else begin
                  w_set_skip   = 1'b1;
                  w_state_next = ST_LOST;
               end
            end
            ST_LOST: begin
               if (w_zero) begin
                  w_state_next = ST_IDLE;
               end else if (w_onehot) begin
                  w_state_next = ST_TRACK;
               end else begin
                  w_set_ill = 1'b1;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cand      <= 4'b0000;
         r_cnt       <= '0;
         r_last      <= 4'b0000;
         r_idle      <= '0;
         position    <= '0;
         step_pulse  <= 1'b0;
         dir         <= 1'b0;
         err_skip    <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         r_cand     <= w_sample;
         r_cnt      <= w_cnt_next;
         step_pulse <= w_inc | w_dec;
         if (w_accept) begin
            r_last <= w_sample;
         end
         if (w_inc) begin
            dir <= 1'b1;
         end else if (w_dec) begin
            dir <= 1'b0;
         end
         // Home switch wins over any step in the same cycle.
         if (at_home) begin
            position <= '0;
         end else if (w_inc && (position != C_POS_MAX)) begin
            position <= position + POS_W'(1);
         end else if (w_dec && (position != C_POS_MIN)) begin
            position <= position - POS_W'(1);
         end
         if (w_inc | w_dec) begin
            r_idle <= C_IDLE;
         end else if (r_idle != '0) begin
            r_idle <= r_idle - IDLE_W'(1);
         end
         err_skip    <= w_set_skip | (err_skip & ~clr_err);
         err_illegal <= w_set_ill | (err_illegal & ~clr_err);
      end
   end

   assign moving = (r_idle != '0);

endmodule

`default_nettype wire

// File: tb/tb_pmod_step_monitor.sv
//==============================================================================
// Module  : tb_pmod_step_monitor
// Brief   : Table, hand-sequence and random checks of pmod_step_monitor against a window-based model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pmod_step_monitor;
   localparam int POS_W = 8, SYNC_STAGES = 2, STABLE_CYCLES = 4, IDLE_TIMEOUT = 50;

   logic clk = 1'b0, rst = 1'b0, clr_err = 1'b0;
   logic [3:0] signal_in = 4'b0000;
   logic [1:0] limit_in = 2'b00;
   logic signed [POS_W-1:0] position;
   logic step_pulse, dir, moving, at_home, at_end, err_skip, err_illegal;

   always #5 clk = ~clk;

   pmod_step_monitor #(.POS_W(POS_W), .SYNC_STAGES(SYNC_STAGES),
                       .STABLE_CYCLES(STABLE_CYCLES), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .signal_in(signal_in), .limit_in(limit_in), .clr_err(clr_err),
      .position(position), .step_pulse(step_pulse), .dir(dir), .moving(moving),
      .at_home(at_home), .at_end(at_end), .err_skip(err_skip), .err_illegal(err_illegal));

   int checks = 0, errors = 0, npulse = 0;

   // Reference model: inputs delayed through queues, acceptance judged on a window of samples.
   logic [3:0] mq[$];
   logic [1:0] lq[$];
   int seen[$];
   logic [3:0] m_last;
   int m_mode;  // 0 idle, 1 tracking, 2 lost
   int m_pos, m_since;
   bit m_step, m_dir, m_home, m_end, m_skip, m_ill;

   typedef struct {
      logic [3:0] sig;
      int         hold;
      bit         clr;
      int         pos;
      bit         dir;
      bit         skip;
      bit         ill;
   } vec_t;
   vec_t tbl[13];

   function automatic int ph_idx(input logic [3:0] p);
      case (p)
         4'b1000: return 0;
         4'b0100: return 1;
         4'b0010: return 2;
         4'b0001: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] ph_of(input int idx);
      logic [3:0] base;
      base = 4'b1000;
      return base >> ((idx % 4 + 4) % 4);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete(); mq.push_back(4'b0000); mq.push_back(4'b0000);
      lq.delete(); lq.push_back(2'b00); lq.push_back(2'b00);
      seen.delete(); seen.push_back(-1);
      m_last = 4'b0000; m_mode = 0; m_pos = 0; m_since = 1000;
      m_step = 0; m_dir = 0; m_home = 0; m_end = 0; m_skip = 0; m_ill = 0;
   endtask

   task automatic model_edge();
      logic [3:0] s;
      int run, ni, li, d, nxt;
      bit acc, set_skip, set_ill;
      if (!rst) begin
         model_reset();
         return;
      end
      s = mq.pop_front(); mq.push_back(signal_in);
      void'(lq.pop_front()); lq.push_back(limit_in);
      seen.push_back(int'(s));
      if (seen.size() > 5) void'(seen.pop_front());
      run = 0;
      for (int i = seen.size() - 1; i >= 0 && seen[i] == int'(s); i--) run++;
      acc = (run == STABLE_CYCLES) && (s != m_last);
      m_step = 0; set_skip = 0; set_ill = 0; nxt = m_pos;
      if (acc) begin
         ni = ph_idx(s);
         li = ph_idx(m_last);
         if (s == 4'b0000) m_mode = 0;
         else if (ni < 0) begin set_ill = 1; m_mode = 2; end
         else if (m_mode == 1) begin
            d = (ni - li + 4) % 4;
            if (d == 1) begin m_step = 1; m_dir = 1; nxt = m_pos + 1; end
            else if (d == 3) begin m_step = 1; m_dir = 0; nxt = m_pos - 1; end
            else begin set_skip = 1; m_mode = 2; end
         end else m_mode = 1;
         m_last = s;
      end
      m_skip = set_skip | (m_skip & !clr_err);
      m_ill  = set_ill | (m_ill & !clr_err);
      if (m_home) m_pos = 0;
      else m_pos = (nxt > 127) ? 127 : ((nxt < -128) ? -128 : nxt);
      m_home = lq[0][0];
      m_end  = lq[0][1];
      m_since = m_step ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
   endtask

   task automatic compare_all();
      chk("position", int'(position), m_pos);
      chk("step_pulse", int'(step_pulse), int'(m_step));
      chk("dir", int'(dir), int'(m_dir));
      chk("moving", int'(moving), int'(m_since < IDLE_TIMEOUT));
      chk("at_home", int'(at_home), int'(m_home));
      chk("at_end", int'(at_end), int'(m_end));
      chk("err_skip", int'(err_skip), int'(m_skip));
      chk("err_illegal", int'(err_illegal), int'(m_ill));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (step_pulse) npulse++;
   endtask

   task automatic hold(input logic [3:0] p, input int n);
      signal_in = p;
      repeat (n) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, hi, k, cur;
      logic [3:0] v;

      tbl[0]  = '{4'b1000, 10, 0, 0, 0, 0, 0};
      tbl[1]  = '{4'b0100, 10, 0, 1, 1, 0, 0};
      tbl[2]  = '{4'b0010, 10, 0, 2, 1, 0, 0};
      tbl[3]  = '{4'b0001, 10, 0, 3, 1, 0, 0};
      tbl[4]  = '{4'b1000, 10, 0, 4, 1, 0, 0};
      tbl[5]  = '{4'b0100, 10, 0, 5, 1, 0, 0};
      tbl[6]  = '{4'b1000, 10, 0, 4, 0, 0, 0};
      tbl[7]  = '{4'b0001,  2, 0, 4, 0, 0, 0};
      tbl[8]  = '{4'b0010, 10, 0, 4, 0, 1, 0};
      tbl[9]  = '{4'b1100, 10, 0, 4, 0, 1, 1};
      tbl[10] = '{4'b0100, 10, 0, 4, 0, 1, 1};
      tbl[11] = '{4'b0010, 10, 0, 5, 1, 1, 1};
      tbl[12] = '{4'b0010,  3, 1, 5, 1, 0, 0};

      model_reset();
      repeat (3) cycle();
      rst = 1'b1;
      repeat (3) cycle();

      for (int i = 0; i < 13; i++) begin
         signal_in = tbl[i].sig;
         clr_err   = tbl[i].clr;
         cycle();
         clr_err = 1'b0;
         repeat (tbl[i].hold - 1) cycle();
         chk($sformatf("tbl%0d_pos", i), int'(position), tbl[i].pos);
         chk($sformatf("tbl%0d_dir", i), int'(dir), int'(tbl[i].dir));
         chk($sformatf("tbl%0d_skip", i), int'(err_skip), int'(tbl[i].skip));
         chk($sformatf("tbl%0d_ill", i), int'(err_illegal), int'(tbl[i].ill));
      end

      // Forward step 0010 -> 0001: pulse exactly on the 6th edge after the change.
      signal_in = 4'b0001;
      for (int e = 1; e <= 8; e++) begin
         cycle();
         chk($sformatf("latency_edge%0d", e), int'(step_pulse), int'(e == 6));
      end
      chk("latency_pos", int'(position), 6);

      // Two-phase jump accepted in the same cycle as clr_err: flag must end set.
      signal_in = 4'b0100;
      repeat (5) cycle();
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      chk("skip_vs_clr", int'(err_skip), 1);
      hold(4'b1000, 8);
      chk("resync_pos", int'(position), 6);

      // Saturation at +127.
      p0 = npulse;
      cur = 0;
      for (int s = 0; s < 130; s++) begin
         cur++;
         hold(ph_of(cur), 6);
      end
      chk("sat_pos", int'(position), 127);
      chk("sat_pulses", npulse - p0, 130);

      // Home forces zero two sync stages plus one edge after the switch closes.
      limit_in = 2'b01;
      cycle(); cycle();
      chk("home_sync", int'(at_home), 1);
      chk("home_pos_pre", int'(position), 127);
      cycle();
      chk("home_pos", int'(position), 0);
      p0 = npulse;
      for (int s = 0; s < 8; s++) begin
         cur++;
         hold(ph_of(cur), 6);
      end
      chk("home_pulses", npulse - p0, 8);
      chk("home_hold", int'(position), 0);
      limit_in = 2'b10;
      repeat (3) cycle();
      chk("end_flag", int'(at_end), 1);
      limit_in = 2'b00;
      repeat (3) cycle();

      // moving stays high for IDLE_TIMEOUT cycles starting with the pulse.
      cur++;
      signal_in = ph_of(cur);
      k = 0;
      do begin cycle(); k++; end while (!step_pulse && k < 20);
      chk("timeout_pulse_seen", int'(step_pulse), 1);
      hi = 1;
      while (hi < 200) begin
         cycle();
         if (!moving) break;
         hi++;
      end
      chk("moving_cycles", hi, IDLE_TIMEOUT);

      // Reset in the middle of a filter run; the next phase after reset is not counted.
      signal_in = 4'b0100;
      cycle(); cycle();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_pos", int'(position), 0);
      chk("rst_flags", int'({step_pulse, dir, moving, err_skip, err_illegal}), 0);
      cycle(); cycle();
      rst = 1'b1;
      p0 = npulse;
      hold(4'b0100, 10);
      chk("post_rst_pulses", npulse - p0, 0);
      chk("post_rst_pos", int'(position), 0);
      hold(4'b0010, 10);
      chk("post_rst_step", int'(position), 1);

      // Randomised segments checked every cycle against the model.
      cur = 2;
      for (int seg = 0; seg < 400; seg++) begin
         k = $urandom_range(0, 99);
         if (k < 40) begin cur++; v = ph_of(cur); end
         else if (k < 70) begin cur--; v = ph_of(cur); end
         else if (k < 76) begin cur += 2; v = ph_of(cur); end
         else if (k < 82) v = 4'b0000;
         else if (k < 88) begin
            do v = 4'($urandom_range(1, 15)); while ((v & (v - 4'd1)) == 4'b0000);
         end else begin cur = $urandom_range(0, 3); v = ph_of(cur); end
         signal_in = v;
         limit_in = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b0;
            model_reset();
            cycle();
            rst = 1'b1;
         end
         hi = $urandom_range(1, 8);
         for (int c = 0; c < hi; c++) begin
            clr_err = ($urandom_range(0, 29) == 0);
            cycle();
         end
         clr_err = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
